// File: rtl/fios_pkg.sv
// rtl/fios_pkg.sv - shared types, constants and helpers for the FIOS result path
// Contents:
//   WIDTH_DEFAULT      default digit width, shared with the processing-element wrappers
//   collector_state_t  collector FSM states
//   clog2_ptr()        FIFO pointer width: log2(depth) plus one wrap bit
package fios_pkg;

   localparam int WIDTH_DEFAULT = 17;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FLUSH   = 2'd2
   } collector_state_t;

   // The extra MSB distinguishes full from empty when the index bits match.
   function automatic int clog2_ptr(input int depth);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) w = i + 1;
      end
      return w + 1;
   endfunction

endpackage

// File: rtl/fios_result_collector_if.sv
// rtl/fios_result_collector_if.sv - handshake bundle between the PE output, collector and consumer
// Signals:
//   start_i, P_valid_i, P_i      arm / partial-word input side
//   digit_o, digit_valid_o, digit_ready_i, last_o   digit stream
//   busy_o, done_o, carry_out_o, overrun_o          status
// Modports: slave (collector side), master (driver / consumer side)
interface fios_result_collector_if #(
   parameter int WIDTH = fios_pkg::WIDTH_DEFAULT
);
   logic               start_i;
   logic               P_valid_i;
   logic [2*WIDTH-1:0] P_i;
   logic [WIDTH-1:0]   digit_o;
   logic               digit_valid_o;
   logic               digit_ready_i;
   logic               last_o;
   logic               busy_o;
   logic               done_o;
   logic               carry_out_o;
   logic               overrun_o;

   modport slave (
      input  start_i, P_valid_i, P_i, digit_ready_i,
      output digit_o, digit_valid_o, last_o, busy_o, done_o, carry_out_o, overrun_o
   );

   modport master (
      output start_i, P_valid_i, P_i, digit_ready_i,
      input  digit_o, digit_valid_o, last_o, busy_o, done_o, carry_out_o, overrun_o
   );
endinterface

// File: rtl/fios_digit_fifo.sv
// rtl/fios_digit_fifo.sv - first-word-fall-through FIFO for tagged result digits
// Ports:
//   clock_i, reset_n_i   clock, asynchronous active-low reset
//   push_i, data_i       write side (caller guarantees !full_o or a same-cycle pop)
//   pop_i, data_o        read side; data_o shows the head entry while !empty_o
//   full_o, empty_o      occupancy flags
module fios_digit_fifo
   import fios_pkg::*;
#(
   parameter int DATA_W = 18,
   parameter int DEPTH  = 4
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int PW = clog2_ptr(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;

   // When full, the write slot equals the head slot; a simultaneous pop has
   // already consumed the head this cycle, so overwriting it is safe.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (push_i) begin
            r_mem[r_wptr[PW-2:0]] <= data_i;
            r_wptr                <= r_wptr + PW'(1);
         end
         if (pop_i) r_rptr <= r_rptr + PW'(1);
      end
   end

   assign data_o  = r_mem[r_rptr[PW-2:0]];
   assign empty_o = (r_wptr == r_rptr);
   assign full_o  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);

endmodule

// File: rtl/fios_result_collector.sv
// rtl/fios_result_collector.sv - resolves radix-2^WIDTH carries of FIOS partial words into a digit stream
// Ports:
//   clock_i, reset_n_i   clock, asynchronous active-low reset
//   bus (slave)          start/partial-word input, digit stream out, busy/done/carry_out/overrun status
module fios_result_collector
   import fios_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEFAULT,
   parameter int S          = 61,
   parameter int FIFO_DEPTH = 4
) (
   input logic                  clock_i,
   input logic                  reset_n_i,
   fios_result_collector_if.slave bus
);
   localparam int CW = (S > 1) ? $clog2(S) : 1;

   collector_state_t r_state;
   collector_state_t w_next_state;

   logic [WIDTH:0]   r_carry;
   logic [CW-1:0]    r_count;
   logic             r_done;
   logic             r_carry_out;
   logic             r_overrun;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push_req;
   logic             w_push;
   logic             w_last_word;
   logic             w_last_pop;
   logic             w_busy;
   logic [2*WIDTH:0] w_sum;
   logic [WIDTH:0]   w_wr_data;
   logic [WIDTH:0]   w_rd_data;

   assign w_sum       = {1'b0, bus.P_i} + {{WIDTH{1'b0}}, r_carry};
   assign w_last_word = (r_count == CW'(S - 1));
   assign w_pop       = !w_empty && bus.digit_ready_i;
   assign w_push_req  = (r_state == COLLECT) && bus.P_valid_i;
   // A full FIFO still takes the word if the head leaves in the same cycle.
   assign w_push      = w_push_req && (!w_full || w_pop);
   assign w_wr_data   = {w_last_word, w_sum[WIDTH-1:0]};
   assign w_last_pop  = (r_state == FLUSH) && w_pop && w_rd_data[WIDTH];

   fios_digit_fifo #(
      .DATA_W (WIDTH + 1),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .push_i    (w_push),
      .data_i    (w_wr_data),
      .pop_i     (w_pop),
      .data_o    (w_rd_data),
      .full_o    (w_full),
      .empty_o   (w_empty)
   );

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= IDLE;
      else            r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.start_i)              w_next_state = COLLECT;
         COLLECT: if (w_push && w_last_word)    w_next_state = FLUSH;
         FLUSH:   if (w_last_pop)               w_next_state = IDLE;
         default:                               w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state != IDLE);
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_carry     <= '0;
         r_count     <= '0;
         r_done      <= 1'b0;
         r_carry_out <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_done <= w_last_pop;
         if (r_state == IDLE && bus.start_i) begin
            r_carry     <= '0;
            r_count     <= '0;
            r_carry_out <= 1'b0;
            r_overrun   <= 1'b0;
         end
         if (w_push) begin
            r_carry <= w_sum[2*WIDTH:WIDTH];
            r_count <= r_count + CW'(1);
         end
         // Dropped word: carry/count untouched so the next word takes its slot.
         if (w_push_req && !w_push) r_overrun <= 1'b1;
         if (w_last_pop) r_carry_out <= |r_carry;
      end
   end

   assign bus.digit_o       = w_rd_data[WIDTH-1:0];
   assign bus.digit_valid_o = !w_empty;
   assign bus.last_o        = !w_empty && w_rd_data[WIDTH];
   assign bus.busy_o        = w_busy;
   assign bus.done_o        = r_done;
   assign bus.carry_out_o   = r_carry_out;
   assign bus.overrun_o     = r_overrun;

endmodule
